// File: rtl/dfb_pkg.sv
// Shared definitions for the dfb audio stream buffers.
package dfb_pkg;

  localparam int AUDIO_W = 24;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dfb_fifo_ptr.sv
// Wrapping read/write pointers and occupancy count for a power-of-two FIFO.
module dfb_fifo_ptr
  import dfb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH)-1:0]   o_wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
  output logic [cnt_w(DEPTH)-1:0]    o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/dfb_fifo.sv
// Elastic valid/ready buffer for tagged audio samples, with occupancy and almost-full status.
module dfb_fifo
  import dfb_pkg::*;
#(
  parameter int DATA_W   = AUDIO_W,
  parameter int CH_W     = 1,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [CH_W-1:0]          i_chan,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_chan,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_afull
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  typedef struct packed {
    logic [CH_W-1:0]   chan;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic             r_rst_q;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  entry_t           w_head;

  assign w_push = i_valid && o_ready;
  assign w_pop  = o_valid && i_ready;

  dfb_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (flush),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Holds o_ready low for the cycle following a reset edge.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst && !flush) r_mem[w_wr_ptr] <= {i_chan, i_data};
  end

  assign w_head  = r_mem[w_rd_ptr];
  assign o_ready = !r_rst_q && !w_full;
  assign o_valid = !w_empty;
  assign o_data  = w_head.data;
  assign o_chan  = w_head.chan;
  assign o_count = w_count;
  assign o_afull = (w_count >= CNT_W'(AFULL_TH));

endmodule

// File: tb/tb_dfb_fifo.sv
// Randomized and directed bench for dfb_fifo against a queue-based reference model.
module tb_dfb_fifo;

  localparam int DATA_W = 24;
  localparam int CH_W   = 1;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [DATA_W-1:0] i_data = '0;
  logic [CH_W-1:0]   i_chan = '0;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic [DATA_W-1:0] o_data;
  logic [CH_W-1:0]   o_chan;
  logic [2:0]        o_count;
  logic              o_afull;

  dfb_fifo #(.DATA_W(DATA_W), .CH_W(CH_W), .DEPTH(DEPTH), .AFULL_TH(AFULL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_chan(i_chan),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_chan(o_chan),
    .o_count(o_count), .o_afull(o_afull)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {chan,data}, plus the "just reset" flag.
  logic [CH_W+DATA_W-1:0] q[$];
  bit  m_rstflag = 1'b1;
  bit  chk_en = 1'b0;
  int  n_push = 0;
  int  n_pop  = 0;

  always @(posedge clk) begin
    bit m_ready, m_valid;
    m_ready = !m_rstflag && (q.size() < DEPTH);
    m_valid = (q.size() != 0);
    if (rst) begin
      q.delete();
      m_rstflag = 1'b1;
    end else begin
      m_rstflag = 1'b0;
      if (flush) q.delete();
      else begin
        if (m_valid && i_ready) begin
          void'(q.pop_front());
          n_pop++;
        end
        if (i_valid && m_ready) begin
          q.push_back({i_chan, i_data});
          n_push++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", o_valid, q.size() != 0);
      check("o_ready", o_ready, !m_rstflag && (q.size() < DEPTH));
      check("o_count", o_count, q.size());
      check("o_afull", o_afull, q.size() >= AFULL);
      if (q.size() != 0) begin
        check("o_data", o_data, q[0][DATA_W-1:0]);
        check("o_chan", o_chan, q[0][CH_W+DATA_W-1:DATA_W]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    // Reset then idle
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rel_ready", o_ready, 1);
    check("rel_valid", o_valid, 0);
    check("rel_count", o_count, 0);
    check("rel_afull", o_afull, 0);

    // Single sample
    i_valid = 1'b1; i_data = 24'h123456; i_chan = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    check("single_valid", o_valid, 1);
    check("single_data", o_data, 24'h123456);
    check("single_chan", o_chan, 1);
    tick();
    check("single_count", o_count, 0);

    // Fill to full
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      i_valid = 1'b1; i_data = DATA_W'(k); i_chan = CH_W'(k);
      tick();
      if (k == 3) check("fill_afull3", o_afull, 1);
      if (k == 4) check("fill_ready4", o_ready, 0);
    end
    i_data = 24'h000005;
    tick();
    check("fill_no5th", o_count, 4);
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_order", o_data, k);
      tick();
    end
    check("drain_empty", o_count, 0);

    // Sustained streaming
    for (int n = 0; n < 64; n++) begin
      i_valid = 1'b1; i_data = DATA_W'($urandom); i_chan = CH_W'(n & 1);
      tick();
      check("stream_count", o_count, 1);
    end
    i_valid = 1'b0;
    tick();

    // Random backpressure
    n_push = 0;
    cyc = 0;
    while (n_push < 1000 && cyc < 20000) begin
      i_valid = $urandom_range(0, 1) == 1;
      i_ready = $urandom_range(0, 1) == 1;
      i_data  = DATA_W'($urandom);
      i_chan  = CH_W'($urandom);
      tick();
      cyc++;
    end
    check("rand_done", n_push >= 1000, 1);

    // Flush mid-stream
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = DATA_W'(24'hA0 + k);
      tick();
    end
    check("pre_flush_count", o_count, 3);
    flush = 1'b1; i_data = 24'hBEEF;
    tick();
    flush = 1'b0; i_valid = 1'b0;
    check("flush_valid", o_valid, 0);
    check("flush_count", o_count, 0);
    check("flush_ready", o_ready, 1);
    tick();
    check("flush_discard", o_count, 0);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = DATA_W'(24'hC0 + k);
      tick();
    end
    check("pre_rst_count", o_count, 3);
    rst = 1'b1; i_data = 24'hDEAD;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    tick();
    check("rst_ready_back", o_ready, 1);
    check("rst_discard", o_count, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dfb_fifo.md
Name: dfb_fifo

Overview:
- Parametrised successor to the single-stage dfb valid/ready buffer.
- An elastic buffer of DEPTH entries on the audio valid/ready stream, with configurable sample width and a channel-tag sideband for interleaved multichannel audio.
- Adds occupancy and almost-full status plus a synchronous flush.
- Sits between audio producers and consumers wherever more than one sample of slack or cross-block decoupling is needed.

Parameters:
DATA_W, 24, sample width in bits (≥1)
CH_W, 1, channel-tag width in bits (≥1); tag travels with its sample
DEPTH, 4, number of entries; power of two, ≥2
AFULL_TH, 3, o_afull asserts when occupancy ≥ AFULL_TH (1..DEPTH)

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents, active-high
i_valid  in  1  upstream sample valid
o_ready  out  1  buffer can accept
i_data  in  DATA_W  upstream sample
i_chan  in  CH_W  upstream channel tag
o_valid  out  1  downstream sample valid
i_ready  in  1  downstream can accept
o_data  out  DATA_W  downstream sample
o_chan  out  CH_W  downstream channel tag
o_count  out  $clog2(DEPTH+1)  current occupancy
o_afull  out  1  occupancy ≥ AFULL_TH

Behaviour:
- Handshakes:
  - push = i_valid & o_ready.
  - pop = o_valid & i_ready.
  - Transfer happens on the clock edge where both valid and ready are high.
- Storage: DEPTH-entry register array holding {chan, data}; wr_ptr and rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH naturally; count register tracks occupancy.
- Reset (rst=1 at edge):
  - wr_ptr=rd_ptr=count=0.
  - Outputs: o_valid=0, o_ready=0 during the reset cycle, then 1; o_count=0, o_afull=0.
  - o_data/o_chan are don't-care while o_valid=0.
  - Storage contents are not reset.
  - rst overrides flush and any push/pop in the same cycle.
- Flush: same effect as reset on pointers and count, except o_ready stays 1. A push in the flush cycle is discarded.
- o_ready = (count != DEPTH). It is derived only from registered state and has no combinational path from i_valid or i_ready.
- o_valid = (count != 0). o_data/o_chan = mem[rd_ptr]. These are driven from registers only, with no combinational path from the i_* inputs.
- Latency: a sample pushed into an empty buffer appears on o_valid the next cycle. There is no fall-through.
- Throughput: one push and one pop per cycle sustained.
- Occupancy update:
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full (count=DEPTH): o_ready=0, so no push is possible even if a pop occurs that cycle; o_ready returns the cycle after the pop.
  - Empty (count=0): o_valid=0, so i_ready is ignored.
- Ordering: strict FIFO. The channel tag is never reordered relative to its data.
- Output stability: o_valid, o_data and o_chan hold stable while o_valid=1 and i_ready=0.
- o_count and o_afull are registered and reflect post-edge occupancy.
- Back-to-back instances compose with no combinational loop between them.

Decomposition:
- Package dfb_pkg:
  - default AUDIO_W=24;
  - entry struct type helper (chan, data) parametrised by widths via typedef in the module;
  - function clog2-based count width.
- One natural sub-module: dfb_fifo_ptr, a wrapping pointer/count unit with inputs push/pop/clr and outputs wr_ptr, rd_ptr, count, full, empty.
- The storage array stays in dfb_fifo.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: o_valid=0, o_count=0, o_afull=0; o_ready=1 from the first cycle after release.
- Single sample:
  - Stimulus: push data=24'h123456, chan=1 into the empty buffer with i_ready=1.
  - Required: o_valid=1 exactly one cycle later with o_data=24'h123456 and o_chan=1; o_count returns to 0 the cycle after the pop.
- Fill to full:
  - Stimulus: DEPTH=4, i_ready=0, push 0x000001..0x000004.
  - Required: o_afull=1 after the 3rd push; o_ready=0 after the 4th; a 5th i_valid is not accepted; then i_ready=1 drains 1,2,3,4 in order.
- Sustained streaming:
  - Stimulus: 64 samples, i_valid=i_ready=1 continuously, alternating chan 0/1.
  - Required: one output per cycle after 1-cycle latency; data and chan match in order; o_count stays at 1.
- Random backpressure:
  - Stimulus: 1000 samples with random i_valid/i_ready at 50% each.
  - Required: scoreboard shows no loss, duplication or reorder; o_data is stable while stalled; o_count never exceeds 4.
- Flush and reset mid-stream:
  - Stimulus: with 3 entries held, assert flush together with a push.
  - Required: next cycle o_valid=0, o_count=0, pushed sample discarded.
  - Stimulus: repeat with rst instead.
  - Required: the same result, plus o_ready=0 during the rst cycle.
